// File: rtl/mdc_master_if.sv
// Handshake bundle between the front end, mdc_master and the MDC core.
// Signal names keep the core-side naming (enb_i, busy_o, ...) seen from the core.
interface mdc_master_if #(
    parameter int DATA_W = 8
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [DATA_W-1:0] req_x_i;
    logic [DATA_W-1:0] req_y_i;
    logic              enb_i;
    logic [DATA_W-1:0] dtx_i;
    logic [DATA_W-1:0] dty_i;
    logic              busy_o;
    logic [DATA_W-1:0] dt_o;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_dt_o;
    logic              rsp_err_o;

    modport master (
        input  req_valid_i, req_x_i, req_y_i, busy_o, dt_o, rsp_ready_i,
        output req_ready_o, enb_i, dtx_i, dty_i, rsp_valid_o, rsp_dt_o, rsp_err_o
    );

    modport slave (
        output req_valid_i, req_x_i, req_y_i, busy_o, dt_o, rsp_ready_i,
        input  req_ready_o, enb_i, dtx_i, dty_i, rsp_valid_o, rsp_dt_o, rsp_err_o
    );
endinterface

// File: rtl/mdc_master.sv
// Initiator for the MDC (GCD) core: one operand pair in flight, start/done watchdogs.
// Optional macro MDC_MASTER_ZERO_BYPASS_EN answers zero-operand requests without the core.
module mdc_master #(
    parameter int DATA_W     = 8,
    parameter int START_WAIT = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mdc_master_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_t;

    localparam logic [7:0] START_LIM   = 8'(START_WAIT);
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);

    state_t            r_state;
    logic [7:0]        r_cnt;
    logic              r_enb;
    logic [DATA_W-1:0] r_dtx;
    logic [DATA_W-1:0] r_dty;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_dt;
    logic              r_rsp_err;
    logic [7:0]        w_cnt_inc;
    logic              w_req_ready;

    assign w_req_ready     = (r_state == IDLE) && !bus.busy_o && !rst_i;
    assign bus.req_ready_o = w_req_ready;
    assign bus.enb_i       = r_enb;
    assign bus.dtx_i       = r_dtx;
    assign bus.dty_i       = r_dty;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_dt_o    = r_rsp_dt;
    assign bus.rsp_err_o   = r_rsp_err;

    // Saturating watchdog increment; the FSM leaves before the limit anyway.
    always_comb begin
        w_cnt_inc = r_cnt;
        if (r_cnt != 8'hFF) begin
            w_cnt_inc = r_cnt + 8'd1;
        end else begin
            w_cnt_inc = r_cnt;
        end
    end

    // Transaction FSM with registered core strobe and response outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_cnt       <= 8'd0;
            r_enb       <= 1'b0;
            r_dtx       <= {DATA_W{1'b0}};
            r_dty       <= {DATA_W{1'b0}};
            r_rsp_valid <= 1'b0;
            r_rsp_dt    <= {DATA_W{1'b0}};
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_enb <= 1'b0;
                    if (bus.req_valid_i && w_req_ready) begin
`ifdef MDC_MASTER_ZERO_BYPASS_EN
                        if ((bus.req_x_i == {DATA_W{1'b0}}) || (bus.req_y_i == {DATA_W{1'b0}})) begin
                            r_rsp_dt    <= bus.req_x_i | bus.req_y_i;
                            r_rsp_err   <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= RESP;
                        end else begin
                            r_dtx   <= bus.req_x_i;
                            r_dty   <= bus.req_y_i;
                            r_enb   <= 1'b1;
                            r_state <= ISSUE;
                        end
`else
                        r_dtx   <= bus.req_x_i;
                        r_dty   <= bus.req_y_i;
                        r_enb   <= 1'b1;
                        r_state <= ISSUE;
`endif
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ISSUE: begin
                    r_enb   <= 1'b0;
                    r_cnt   <= 8'd0;
                    r_state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    r_enb <= 1'b0;
                    if (bus.busy_o) begin
                        r_cnt   <= 8'd0;
                        r_state <= WAIT_DONE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc >= START_LIM) begin
                            r_rsp_dt    <= {DATA_W{1'b0}};
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= RESP;
                        end else begin
                            r_state <= WAIT_BUSY;
                        end
                    end
                end
                WAIT_DONE: begin
                    // dt_o is trusted only in the cycle the core drops busy.
                    if (!bus.busy_o) begin
                        r_rsp_dt    <= bus.dt_o;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc >= TIMEOUT_LIM) begin
                            r_rsp_dt    <= {DATA_W{1'b0}};
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= RESP;
                        end else begin
                            r_state <= WAIT_DONE;
                        end
                    end
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end else begin
                        r_state <= RESP;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_enb       <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mdc_master.sv
// Scoreboard bench for mdc_master with a behavioural GCD core on the far side.
module tb_mdc_master;
    localparam int DW = 8;
    localparam int MODE_NORMAL = 0;
    localparam int MODE_NEVER  = 1;
    localparam int MODE_STUCK  = 2;

    typedef struct packed {
        logic [DW-1:0] dt;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mdc_master_if #(.DATA_W(DW)) ifc ();

    mdc_master #(.DATA_W(DW), .START_WAIT(4), .TIMEOUT(255)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifc)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   enb_cnt = 0;
    logic prev_enb = 1'b0;

    // behavioural core
    int            core_mode = MODE_NORMAL;
    int            core_len  = 5;
    int            core_cnt  = 0;
    logic          core_busy = 1'b0;
    logic          ext_busy  = 1'b0;
    logic [DW-1:0] core_dt   = '0;
    assign ifc.busy_o = core_busy | ext_busy;
    assign ifc.dt_o   = core_dt;

    bit   rdy_rand  = 1'b0;
    logic rdy_force = 1'b1;

    function automatic logic [DW-1:0] ref_gcd(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] x, y, t;
        x = a; y = b;
        while (y != '0) begin
            t = x % y; x = y; y = t;
        end
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            core_busy <= 1'b0;
            core_cnt  <= 0;
            core_dt   <= '0;
        end else if (ifc.enb_i && core_mode == MODE_NORMAL) begin
            core_busy <= 1'b1;
            core_cnt  <= core_len;
            core_dt   <= DW'($urandom);
        end else if (ifc.enb_i && core_mode == MODE_STUCK) begin
            core_busy <= 1'b1;
            core_cnt  <= 1;
        end else if (core_busy && core_mode != MODE_STUCK) begin
            if (core_cnt <= 1) begin
                core_busy <= 1'b0;
                core_dt   <= ref_gcd(ifc.dtx_i, ifc.dty_i);
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rdy_rand) ifc.rsp_ready_i = 1'($urandom_range(0, 1));
        else          ifc.rsp_ready_i = rdy_force;
    end

    // monitor: scoreboard pop, hold stability, enb pulse width
    logic          held = 1'b0;
    logic [DW-1:0] held_dt;
    logic          held_err;
    always @(negedge clk) begin
        if (ifc.enb_i) begin
            enb_cnt++;
            chk("enb_single_cycle", {31'd0, prev_enb}, 32'd0);
        end
        prev_enb = ifc.enb_i;
        if (ifc.rsp_valid_o && held) begin
            chk("hold_dt", ifc.rsp_dt_o, held_dt);
            chk("hold_err", ifc.rsp_err_o, held_err);
        end
        if (ifc.rsp_valid_o && !ifc.rsp_ready_i) begin
            held = 1'b1; held_dt = ifc.rsp_dt_o; held_err = ifc.rsp_err_o;
        end else begin
            held = 1'b0;
        end
        if (ifc.rsp_valid_o && ifc.rsp_ready_i && !rst) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_dt", ifc.rsp_dt_o, e.dt);
                chk("rsp_err", ifc.rsp_err_o, e.err);
            end
        end
    end

    task automatic do_req(input logic [DW-1:0] x, input logic [DW-1:0] y, input bit push,
                          input logic [DW-1:0] edt, input logic eerr);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        ifc.req_valid_i = 1'b1;
        ifc.req_x_i = x;
        ifc.req_y_i = y;
        while (!ifc.req_ready_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("req_accept_timeout", 32'd1, 32'd0);
        if (push) begin
            e.dt = edt; e.err = eerr;
            q.push_back(e);
        end
        @(posedge clk);
        #1 ifc.req_valid_i = 1'b0;
    endtask

    task automatic wait_valid(input int bound);
        int n;
        n = 0;
        @(negedge clk);
        while (!ifc.rsp_valid_o && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (n >= bound) chk("rsp_valid_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_enb"}, ifc.enb_i, 32'd0);
        chk({tag, "_dtx"}, ifc.dtx_i, 32'd0);
        chk({tag, "_dty"}, ifc.dty_i, 32'd0);
        chk({tag, "_valid"}, ifc.rsp_valid_o, 32'd0);
        chk({tag, "_dt"}, ifc.rsp_dt_o, 32'd0);
        chk({tag, "_err"}, ifc.rsp_err_o, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        logic [DW-1:0] x, y;
        ifc.req_valid_i = 1'b0;
        ifc.req_x_i = '0;
        ifc.req_y_i = '0;
        ifc.rsp_ready_i = 1'b1;

        // reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        chk("ready_in_reset", ifc.req_ready_o, 32'd0);
        rst = 1'b0;
        #1 chk("ready_after_reset", ifc.req_ready_o, 32'd1);

        // 48,18 with 5-cycle busy
        core_len = 5;
        do_req(8'd48, 8'd18, 1'b1, 8'd6, 1'b0);
        @(negedge clk);
        chk("t1_enb_high", ifc.enb_i, 32'd1);
        chk("t1_dtx", ifc.dtx_i, 32'd48);
        chk("t1_dty", ifc.dty_i, 32'd18);
        @(negedge clk);
        chk("t1_enb_low", ifc.enb_i, 32'd0);
        wait_valid(50);

        // minimum latency with 1-cycle busy
        core_len = 1;
        do_req(8'd12, 8'd8, 1'b1, 8'd4, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("lat_not_yet", ifc.rsp_valid_o, 32'd0);
        @(negedge clk);
        chk("lat_t4_valid", ifc.rsp_valid_o, 32'd1);

        // downstream stall
        core_len = 3;
        rdy_force = 1'b0;
        do_req(8'd21, 8'd14, 1'b1, 8'd7, 1'b0);
        wait_valid(50);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", ifc.rsp_valid_o, 32'd1);
            chk("stall_dt", ifc.rsp_dt_o, 32'd7);
            chk("stall_ready_low", ifc.req_ready_o, 32'd0);
        end
        rdy_force = 1'b1;
        @(negedge clk);
        chk("hs_ready_low", ifc.req_ready_o, 32'd0);
        @(negedge clk);
        chk("after_hs_ready", ifc.req_ready_o, 32'd1);
        chk("after_hs_valid", ifc.rsp_valid_o, 32'd0);

        // start timeout
        core_mode = MODE_NEVER;
        do_req(8'd5, 8'd10, 1'b1, 8'd0, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("start_to_not_yet", ifc.rsp_valid_o, 32'd0);
        @(negedge clk);
        chk("start_to_valid", ifc.rsp_valid_o, 32'd1);

        // done timeout
        core_mode = MODE_STUCK;
        do_req(8'd100, 8'd75, 1'b1, 8'd0, 1'b1);
        repeat (256) @(posedge clk);
        @(negedge clk);
        chk("done_to_not_yet", ifc.rsp_valid_o, 32'd0);
        @(negedge clk);
        chk("done_to_valid", ifc.rsp_valid_o, 32'd1);
        core_mode = MODE_NORMAL;
        core_len = 2;
        do_req(8'd9, 8'd3, 1'b1, 8'd3, 1'b0);
        wait_valid(50);

        // reset during WAIT_DONE drops the transaction
        core_len = 20;
        do_req(8'd40, 8'd30, 1'b0, 8'd0, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        chk("midrst_ready", ifc.req_ready_o, 32'd1);
        repeat (30) @(posedge clk);

        // core busy from elsewhere blocks requests
        @(negedge clk);
        ext_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ext_busy_ready", ifc.req_ready_o, 32'd0);
        end
        ext_busy = 1'b0;
        core_len = 2;
        do_req(8'd2, 8'd4, 1'b1, 8'd2, 1'b0);
        wait_valid(50);

        // zero operand
        e0 = enb_cnt;
        do_req(8'd0, 8'd9, 1'b1, 8'd9, 1'b0);
`ifdef MDC_MASTER_ZERO_BYPASS_EN
        @(negedge clk);
        chk("bypass_valid_t1", ifc.rsp_valid_o, 32'd1);
        chk("bypass_dt_t1", ifc.rsp_dt_o, 32'd9);
        chk("bypass_dtx_kept", ifc.dtx_i, 32'd2);
        repeat (5) @(posedge clk);
        chk("bypass_no_enb", enb_cnt - e0, 32'd0);
`else
        wait_valid(50);
        repeat (2) @(posedge clk);
        chk("zero_via_core_enb", enb_cnt - e0, 32'd1);
`endif

        // randomized traffic
        rdy_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            x = DW'($urandom_range(1, 255));
            y = DW'($urandom_range(1, 255));
            if ($urandom_range(0, 9) == 0) x = '0;
            if ($urandom_range(0, 9) == 0) y = DW'(x * DW'($urandom_range(1, 3)));
            core_len = $urandom_range(1, 6);
            do_req(x, y, 1'b1, ref_gcd(x, y), 1'b0);
        end
        rdy_rand = 1'b0;
        rdy_force = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
